// File: rtl/mdu_controller.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Build option MDU_DIV_EN compiles in the divide datapath; without it, div/divu complete as no-ops.
module mdu_controller (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        flush,
    input  logic        hilo_rd,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state, w_state_d;
    logic [4:0]  r_cnt, w_cnt_d;
    logic [63:0] r_acc, w_acc_d;
    logic [31:0] r_opnd, w_opnd_d;
    logic        r_neg_q, w_neg_q_d;
    logic [31:0] r_hi, w_hi_d;
    logic [31:0] r_lo, w_lo_d;
    logic        r_div_zero, w_div_zero_d;

    logic        w_is_div;
    logic        w_neg_r;
    logic        w_signed_in;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_step;
    logic [32:0] w_rem_sh;
    logic        w_div_ge;
    logic [31:0] w_div_diff;
    logic [63:0] w_div_step;
    logic [63:0] w_acc_step;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

`ifdef MDU_DIV_EN
    logic r_div, w_div_d;
    logic r_neg_r, w_neg_r_d;
    assign w_is_div = r_div;
    assign w_neg_r  = r_neg_r;
`else
    assign w_is_div = 1'b0;
    assign w_neg_r  = 1'b0;
`endif

    // Iterations run on magnitudes; signs are reapplied on the final cycle.
    assign w_signed_in = ~op[0];
    assign w_abs_a     = (w_signed_in && operand_a[31]) ? (~operand_a + 32'd1) : operand_a;
    assign w_abs_b     = (w_signed_in && operand_b[31]) ? (~operand_b + 32'd1) : operand_b;

    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
    assign w_mul_step = {w_mul_sum, r_acc[31:1]};

    assign w_rem_sh   = r_acc[63:31];
    assign w_div_ge   = (w_rem_sh >= {1'b0, r_opnd});
    assign w_div_diff = w_rem_sh[31:0] - r_opnd;
    assign w_div_step = {(w_div_ge ? w_div_diff : w_rem_sh[31:0]), r_acc[30:0], w_div_ge};

    assign w_acc_step = w_is_div ? w_div_step : w_mul_step;

    assign w_prod   = r_neg_q ? (~w_acc_step + 64'd1) : w_acc_step;
    assign w_quot   = r_neg_q ? (~w_acc_step[31:0] + 32'd1) : w_acc_step[31:0];
    assign w_rem    = w_neg_r ? (~w_acc_step[63:32] + 32'd1) : w_acc_step[63:32];
    assign w_res_hi = w_is_div ? w_rem : w_prod[63:32];
    assign w_res_lo = w_is_div ? w_quot : w_prod[31:0];

    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign stall    = busy & (start | hilo_rd | hi_we | lo_we);
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_acc_d      = r_acc;
        w_opnd_d     = r_opnd;
        w_neg_q_d    = r_neg_q;
`ifdef MDU_DIV_EN
        w_div_d      = r_div;
        w_neg_r_d    = r_neg_r;
`endif
        w_hi_d       = (hi_we && !busy) ? wdata : r_hi;
        w_lo_d       = (lo_we && !busy) ? wdata : r_lo;
        w_div_zero_d = 1'b0;

        if (flush) begin
            w_state_d = S_IDLE;
        end else begin
            case (r_state)
                S_RUN: begin
                    w_cnt_d = r_cnt + 5'd1;
                    w_acc_d = w_acc_step;
                    if (r_cnt == 5'd31) begin
                        w_state_d = S_DONE;
                        w_hi_d    = w_res_hi;
                        w_lo_d    = w_res_lo;
                    end
                end
                default: begin
                    if (start) begin
                        if (op[1]) begin
`ifdef MDU_DIV_EN
                            if (operand_b == 32'd0) begin
                                w_state_d    = S_DONE;
                                w_hi_d       = operand_a;
                                w_lo_d       = 32'hFFFF_FFFF;
                                w_div_zero_d = 1'b1;
                            end else begin
                                w_state_d = S_RUN;
                                w_cnt_d   = 5'd0;
                                w_acc_d   = {32'd0, w_abs_a};
                                w_opnd_d  = w_abs_b;
                                w_neg_q_d = w_signed_in & (operand_a[31] ^ operand_b[31]);
                                w_neg_r_d = w_signed_in & operand_a[31];
                                w_div_d   = 1'b1;
                            end
`else
                            w_state_d = S_DONE;
`endif
                        end else begin
                            w_state_d = S_RUN;
                            w_cnt_d   = 5'd0;
                            w_acc_d   = {32'd0, w_abs_b};
                            w_opnd_d  = w_abs_a;
                            w_neg_q_d = w_signed_in & (operand_a[31] ^ operand_b[31]);
`ifdef MDU_DIV_EN
                            w_neg_r_d = 1'b0;
                            w_div_d   = 1'b0;
`endif
                        end
                    end else begin
                        w_state_d = S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 5'd0;
            r_acc      <= 64'd0;
            r_opnd     <= 32'd0;
            r_neg_q    <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_div_zero <= 1'b0;
`ifdef MDU_DIV_EN
            r_div      <= 1'b0;
            r_neg_r    <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_acc      <= w_acc_d;
            r_opnd     <= w_opnd_d;
            r_neg_q    <= w_neg_q_d;
            r_hi       <= w_hi_d;
            r_lo       <= w_lo_d;
            r_div_zero <= w_div_zero_d;
`ifdef MDU_DIV_EN
            r_div      <= w_div_d;
            r_neg_r    <= w_neg_r_d;
`endif
        end
    end

endmodule
